sdram_burst_writer: RTL and testbench

//  Parametrised SDRAM full-page burst write engine; successor to sdram_write.

---
 rtl/sdram_burst_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_sdram_burst_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_writer.sv
// SDRAM full-page burst write engine with configurable timing and zero-length requests.
// Define SDRAM_WR_PAGE_SPLIT_EN to split bursts at page boundaries with row/bank carry.
module sdram_burst_writer #(
    parameter int DQ_W  = 16,
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int LEN_W = 10,
    parameter int T_RCD = 2,
    parameter int T_WR  = 2,
    parameter int T_RP  = 2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_end,
    input  logic                        wr_en,
    input  logic [BA_W+ROW_W+COL_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]            wr_burst_len,
    input  logic [DQ_W-1:0]             wr_data,
    output logic                        wr_fifo_rd_en,
    output logic                        wr_end,
    output logic                        wr_busy,
    output logic [3:0]                  write_cmd,
    output logic [BA_W-1:0]             write_ba,
    output logic [ROW_W-1:0]            write_addr,
    output logic                        wr_sdram_en,
    output logic [DQ_W-1:0]             wr_sdram_data
);

    localparam int TW = 8;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [ROW_W-1:0] A10 = ROW_W'(1024);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_WR,
        S_DATA,
        S_BST,
        S_TWR,
        S_PRE,
        S_TRP,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [BA_W-1:0]    bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   seg_q, seg_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [LEN_W-1:0]   seg_len;
    logic               pop;

    logic [3:0]         cmd_q, cmd_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic [ROW_W-1:0]   addr_q, addr_d;
    logic               sd_en_q, sd_en_d;
    logic [DQ_W-1:0]    sd_data_q, sd_data_d;
    logic               end_q, end_d;
    logic               busy_q, busy_d;

`ifdef SDRAM_WR_PAGE_SPLIT_EN
    localparam int SW = (LEN_W > COL_W) ? LEN_W : COL_W + 1;
    logic [SW-1:0] room;
    logic [SW-1:0] rem_w;

    always_comb begin
        room    = SW'(2 ** COL_W) - SW'(col_q);
        rem_w   = SW'(rem_q);
        seg_len = (rem_w < room) ? rem_q : LEN_W'(room);
    end
`else
    always_comb begin
        seg_len = rem_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        rem_d   = rem_q;
        seg_d   = seg_q;
        tcnt_d  = tcnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (init_end && wr_en) begin
                    {bank_d, row_d, col_d} = wr_addr;
                    rem_d   = wr_burst_len;
                    state_d = (wr_burst_len == '0) ? S_END : S_ACT;
                end
            end
            S_ACT: begin
                state_d = S_TRCD;
                tcnt_d  = TW'(T_RCD - 1);
            end
            S_TRCD: begin
                if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else begin
                    // Pop one cycle early so the first word lands with WRITE
                    state_d = S_WR;
                    pop     = 1'b1;
                    seg_d   = seg_len - 1'b1;
                    rem_d   = rem_q - seg_len;
                end
            end
            S_WR, S_DATA: begin
                if (seg_q != '0) begin
                    state_d = S_DATA;
                    pop     = 1'b1;
                    seg_d   = seg_q - 1'b1;
                end else begin
                    state_d = S_BST;
                end
            end
            S_BST: begin
                state_d = S_TWR;
                tcnt_d  = TW'(T_WR - 1);
            end
            S_TWR: begin
                if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                state_d = S_TRP;
                tcnt_d  = TW'(T_RP - 1);
            end
            S_TRP: begin
                if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else if (rem_q != '0) begin
                    state_d = S_ACT;
`ifdef SDRAM_WR_PAGE_SPLIT_EN
                    col_d = '0;
                    if (row_q == '1) begin
                        row_d  = '0;
                        bank_d = bank_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
`endif
                end else begin
                    state_d = S_END;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        cmd_d     = CMD_NOP;
        ba_d      = ba_q;
        addr_d    = '0;
        sd_en_d   = pop;
        sd_data_d = pop ? wr_data : '0;
        end_d     = (state_d == S_END);
        busy_d    = (state_d != S_IDLE);
        unique case (state_d)
            S_ACT: begin
                cmd_d  = CMD_ACT;
                ba_d   = bank_d;
                addr_d = row_d;
            end
            S_WR: begin
                cmd_d  = CMD_WR;
                ba_d   = bank_d;
                addr_d = ROW_W'(col_d);
            end
            S_BST: begin
                cmd_d = CMD_BST;
            end
            S_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = A10;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rem_q     <= '0;
            seg_q     <= '0;
            tcnt_q    <= '0;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
            sd_en_q   <= 1'b0;
            sd_data_q <= '0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rem_q     <= rem_d;
            seg_q     <= seg_d;
            tcnt_q    <= tcnt_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
            sd_en_q   <= sd_en_d;
            sd_data_q <= sd_data_d;
            end_q     <= end_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_fifo_rd_en = pop & ~sys_rst;
    assign wr_end        = end_q;
    assign wr_busy       = busy_q;
    assign write_cmd     = cmd_q;
    assign write_ba      = ba_q;
    assign write_addr    = addr_q;
    assign wr_sdram_en   = sd_en_q;
    assign wr_sdram_data = sd_data_q;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Bench for sdram_burst_writer: table vectors, random requests, reset and init_end sequences.
// Expected command streams come from a per-segment model built from the page rules.
module tb_sdram_burst_writer;

    localparam int DQ_W  = 16;
    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int LEN_W = 10;
    localparam int T_RCD = 2;
    localparam int T_WR  = 2;
    localparam int T_RP  = 2;
    localparam int PAGE  = 1 << COL_W;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    logic                        init_end;
    logic                        wr_en;
    logic [BA_W+ROW_W+COL_W-1:0] wr_addr;
    logic [LEN_W-1:0]            len;
    logic [DQ_W-1:0]             wr_data;
    logic                        rd_en;
    logic                        wend;
    logic                        busy;
    logic [3:0]                  cmd;
    logic [BA_W-1:0]             ba;
    logic [ROW_W-1:0]            addr;
    logic                        sd_en;
    logic [DQ_W-1:0]             sd_data;

    sdram_burst_writer #(
        .DQ_W(DQ_W), .BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W),
        .LEN_W(LEN_W), .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .init_end(init_end),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_burst_len(len),
        .wr_data(wr_data),
        .wr_fifo_rd_en(rd_en),
        .wr_end(wend),
        .wr_busy(busy),
        .write_cmd(cmd),
        .write_ba(ba),
        .write_addr(addr),
        .wr_sdram_en(sd_en),
        .wr_sdram_data(sd_data)
    );

    int fifo_cnt = 0;
    int pops = 0;
    always @(posedge clk) begin
        if (rd_en) begin
            fifo_cnt <= fifo_cnt + 1;
            pops     <= pops + 1;
        end
    end
    assign wr_data = DQ_W'(fifo_cnt);

    typedef struct {
        logic [3:0] cmd;
        int         ba;
        int         addr;
        bit         en;
        int         idx;
        bit         endp;
    } step_t;

    typedef struct {
        int b;
        int r;
        int c;
        int n;
        int acts;
        int words;
    } vec_t;

    step_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [3:0] c, input int b, input int a,
                        input bit en, input int idx, input bit e);
        step_t s;
        s.cmd = c; s.ba = b; s.addr = a; s.en = en; s.idx = idx; s.endp = e;
        exp_q.push_back(s);
    endtask

    task automatic build(input int b0, input int r0, input int c0, input int n);
        int rem, seg, k, b, r, c;
        rem = n; k = 0; b = b0; r = r0; c = c0;
        exp_q.delete();
        while (rem > 0) begin
`ifdef SDRAM_WR_PAGE_SPLIT_EN
            seg = (rem < PAGE - c) ? rem : PAGE - c;
`else
            seg = rem;
`endif
            push(C_ACT, b, r, 0, 0, 0);
            repeat (T_RCD) push(C_NOP, 0, 0, 0, 0, 0);
            for (int i = 0; i < seg; i++)
                push((i == 0) ? C_WR : C_NOP, b, c, 1, k + i, 0);
            k += seg;
            rem -= seg;
            push(C_BST, 0, 0, 0, 0, 0);
            repeat (T_WR) push(C_NOP, 0, 0, 0, 0, 0);
            push(C_PRE, 0, 1024, 0, 0, 0);
            repeat (T_RP) push(C_NOP, 0, 0, 0, 0, 0);
            c = 0;
            r++;
            if (r == (1 << ROW_W)) begin
                r = 0;
                b = (b + 1) % (1 << BA_W);
            end
        end
        push(C_NOP, 0, 0, 0, 0, 1);
    endtask

    task automatic run(input int b, input int r, input int c, input int n,
                       output int acts, output int words);
        int    base, p0;
        step_t s;
        build(b, r, c, n);
        @(negedge clk);
        init_end = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = {BA_W'(b), ROW_W'(r), COL_W'(c)};
        len      = LEN_W'(n);
        base     = fifo_cnt;
        p0       = pops;
        acts     = 0;
        words    = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            s = exp_q[i];
            @(negedge clk);
            chk("cmd", int'(cmd), int'(s.cmd));
            chk("sd_en", int'(sd_en), int'(s.en));
            chk("wr_end", int'(wend), int'(s.endp));
            chk("busy", int'(busy), 1);
            if (cmd == C_ACT) acts++;
            if (sd_en) words++;
            if (s.cmd == C_ACT) begin
                chk("act_ba", int'(ba), s.ba);
                chk("act_row", int'(addr), s.addr);
            end
            if (s.cmd == C_WR) begin
                chk("wr_ba", int'(ba), s.ba);
                chk("wr_col", int'(addr), s.addr);
            end
            if (s.cmd == C_PRE) chk("pre_a10", int'(addr), s.addr);
            if (s.en) chk("data", int'(sd_data), (base + s.idx) & 16'hFFFF);
            wr_en    = (i < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
            wr_addr  = (BA_W+ROW_W+COL_W)'($urandom);
            len      = LEN_W'($urandom);
            init_end = 1'($urandom);
        end
        chk("pops", pops - p0, n);
        @(negedge clk);
        chk("idle_cmd", int'(cmd), int'(C_NOP));
        chk("idle_busy", int'(busy), 0);
        chk("idle_end", int'(wend), 0);
    endtask

    vec_t tbl[7];
    int   acts, words, cnt_a, cnt_b, guard;
    bit   split;

    initial begin
        rst = 1'b1; init_end = 1'b0; wr_en = 1'b0; wr_addr = '0; len = '0;
`ifdef SDRAM_WR_PAGE_SPLIT_EN
        split = 1'b1;
`else
        split = 1'b0;
`endif
        tbl[0] = '{0, 0, 0, 256, 1, 256};
        tbl[1] = '{1, 3, 500, 20, split ? 2 : 1, 20};
        tbl[2] = '{0, 8191, 510, 4, split ? 2 : 1, 4};
        tbl[3] = '{2, 5, 0, 0, 0, 0};
        tbl[4] = '{3, 100, 511, 1, 1, 1};
        tbl[5] = '{3, 8191, 511, 2, split ? 2 : 1, 2};
        tbl[6] = '{1, 7, 0, 512, 1, 512};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", int'(cmd), int'(C_NOP));
        chk("rst_busy", int'(busy), 0);
        chk("rst_end", int'(wend), 0);
        chk("rst_sd_en", int'(sd_en), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_ba_addr", int'({ba, addr}), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run(tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].n, acts, words);
            chk($sformatf("vec%0d_acts", i), acts, tbl[i].acts);
            chk($sformatf("vec%0d_words", i), words, tbl[i].words);
        end

        for (int k = 0; k < 60; k++) begin
            int b, r, c, n;
            b = int'($urandom_range(3, 0));
            r = ($urandom_range(3, 0) == 0) ? 8191 : int'($urandom_range(8191, 0));
            c = ($urandom_range(1, 0) == 0) ? int'($urandom_range(511, 490))
                                            : int'($urandom_range(511, 0));
            n = int'($urandom_range(40, 0));
            run(b, r, c, n, acts, words);
            chk("rnd_words", words, n);
        end

        // Reset in the middle of a long burst
        @(negedge clk);
        init_end = 1'b1; wr_en = 1'b1; wr_addr = '0; len = LEN_W'(256);
        @(posedge clk);
        #1 wr_en = 1'b0;
        words = 0; guard = 0;
        while (words < 100 && guard < 400) begin
            @(negedge clk);
            if (sd_en) words++;
            guard++;
        end
        chk("rst_reach100", words, 100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_cmd", int'(cmd), int'(C_NOP));
        chk("mrst_ba_addr", int'({ba, addr}), 0);
        chk("mrst_sd", int'({sd_en, sd_data}), 0);
        chk("mrst_end_busy", int'({wend, busy}), 0);
        cnt_a = 0;
        repeat (30) begin
            @(negedge clk);
            if (wend) cnt_a++;
            if (cmd != C_NOP) cnt_a++;
        end
        chk("mrst_quiet", cnt_a, 0);

        // Request held off until init_end rises
        init_end = 1'b0; wr_en = 1'b1; wr_addr = '0; len = LEN_W'(4);
        cnt_a = 0; cnt_b = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd != C_NOP) cnt_a++;
            if (busy) cnt_b++;
        end
        chk("noinit_cmd", cnt_a, 0);
        chk("noinit_busy", cnt_b, 0);
        init_end = 1'b1;
        @(negedge clk);
        chk("init_act", int'(cmd), int'(C_ACT));
        wr_en = 1'b0;
        cnt_a = 0; guard = 0;
        while (cnt_a == 0 && guard < 100) begin
            @(negedge clk);
            if (wend) cnt_a++;
            guard++;
        end
        chk("init_done", cnt_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
